multicycle_ctrl: RTL

//  FSM sequencer turning the RV32I datapath into a multicycle machine with one shared instr/data memory.

---
 rtl/multicycle_ctrl.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FSM sequencer for a multicycle RV32I datapath that
// shares one instruction/data memory and stalls on mem_ready.
// Ports:
//   clk, rst_n (sync, active-low)
//   op / funct3 / funct7_5  fields of the instruction register
//   Zero                    ALU zero flag, same cycle
//   mem_ready               memory finished its access this cycle
//   PCWrite, IRWrite, MemWrite, RegWrite   datapath enables
//   AdrSrc, ResultSrc, ALUSrcA, ALUSrcB    datapath mux selects
//   ALUControl, ImmSrc                     ALU function / imm format
//   illegal                 sticky unsupported-opcode flag
//   state_dbg               current state encoding
// State encoding: FETCH=0 DECODE=1 MEMADR=2 MEMREAD=3 MEMWB=4
//   MEMWRITE=5 EXECR=6 EXECI=7 ALUWB=8 BRANCH=9 JAL=10 HALT=11
//   JALR=12 JALRWB=13 (last two only with MC_JALR_EN).
// Build option: define MC_JALR_EN to add jalr support.
module multicycle_ctrl #(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [6:0]         op,
   input  logic [2:0]         funct3,
   input  logic               funct7_5,
   input  logic               Zero,
   input  logic               mem_ready,
   output logic               PCWrite,
   output logic               AdrSrc,
   output logic               IRWrite,
   output logic               MemWrite,
   output logic               RegWrite,
   output logic [1:0]         ResultSrc,
   output logic [1:0]         ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [2:0]         ALUControl,
   output logic [1:0]         ImmSrc,
   output logic               illegal,
   output logic [STATE_W-1:0] state_dbg
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
`ifdef MC_JALR_EN
      S_HALT     = 4'd11,
      S_JALR     = 4'd12,
      S_JALRWB   = 4'd13
`else
      S_HALT     = 4'd11
`endif
   } state_t;

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
`ifdef MC_JALR_EN
   localparam logic [6:0] OP_JALR = 7'b1100111;
`endif

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   state_t     state_q, state_d;
   logic       illegal_q, illegal_d;
   logic [2:0] alu_dec;
   logic       taken;
   logic       pc_upd, branch, ir_we, mem_we, reg_we;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d   = state_q;
      illegal_d = illegal_q | (state_q == S_HALT);
      unique case (state_q)
         S_FETCH:    if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            unique case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXECR;
               OP_I:         state_d = S_EXECI;
               OP_BR:        state_d = S_BRANCH;
               OP_JAL:       state_d = S_JAL;
`ifdef MC_JALR_EN
               OP_JALR:      state_d = S_JALR;
`endif
               default:      state_d = S_HALT;
            endcase
         end
         S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
         S_MEMWB:    state_d = S_FETCH;
         S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
         S_EXECR:    state_d = S_ALUWB;
         S_EXECI:    state_d = S_ALUWB;
         S_ALUWB:    state_d = S_FETCH;
         S_BRANCH:   state_d = S_FETCH;
         S_JAL:      state_d = S_ALUWB;
         S_HALT:     state_d = S_HALT;
`ifdef MC_JALR_EN
         S_JALR:     state_d = S_JALRWB;
         S_JALRWB:   state_d = S_ALUWB;
`endif
         default:    state_d = S_FETCH;
      endcase
   end

   // funct3 -> ALU op; unsupported encodings fall back to add
   always_comb begin
      case (funct3)
         3'b010:  alu_dec = ALU_SLT;
         3'b110:  alu_dec = ALU_OR;
         3'b111:  alu_dec = ALU_AND;
         default: alu_dec = ALU_ADD;
      endcase
   end

   // beq/bne only; other branch funct3 never taken
   always_comb begin
      case (funct3)
         3'b000:  taken = Zero;
         3'b001:  taken = ~Zero;
         default: taken = 1'b0;
      endcase
   end

   // Output logic (Moore, except FETCH's ready-gated enables)
   always_comb begin
      AdrSrc     = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ALUControl = ALU_ADD;
      pc_upd     = 1'b0;
      branch     = 1'b0;
      ir_we      = 1'b0;
      mem_we     = 1'b0;
      reg_we     = 1'b0;
      unique case (state_q)
         S_FETCH: begin
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            ir_we     = mem_ready;
            pc_upd    = mem_ready;
         end
         S_DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
         end
         S_MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
         end
         S_MEMREAD: AdrSrc = 1'b1;
         S_MEMWB: begin
            ResultSrc = 2'b01;
            reg_we    = 1'b1;
         end
         // strobe held through the wait; memory commits on ready
         S_MEMWRITE: begin
            AdrSrc = 1'b1;
            mem_we = 1'b1;
         end
         S_EXECR: begin
            ALUSrcA    = 2'b10;
            ALUControl = (funct3 == 3'b000 && funct7_5) ? ALU_SUB : alu_dec;
         end
         S_EXECI: begin
            ALUSrcA    = 2'b10;
            ALUSrcB    = 2'b01;
            ALUControl = alu_dec;
         end
         S_ALUWB: reg_we = 1'b1;
         S_BRANCH: begin
            ALUSrcA    = 2'b10;
            ALUControl = ALU_SUB;
            branch     = 1'b1;
         end
         S_JAL: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b10;
            pc_upd  = 1'b1;
         end
         S_HALT: ;
`ifdef MC_JALR_EN
         S_JALR: begin
            ALUSrcA   = 2'b10;
            ALUSrcB   = 2'b01;
            ResultSrc = 2'b10;
            pc_upd    = 1'b1;
         end
         S_JALRWB: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b10;
         end
`endif
         default: ;
      endcase
   end

   // Immediate format straight from the opcode
   always_comb begin
      case (op)
         OP_SW:   ImmSrc = 2'b01;
         OP_BR:   ImmSrc = 2'b10;
         OP_JAL:  ImmSrc = 2'b11;
         default: ImmSrc = 2'b00;
      endcase
   end

   assign PCWrite   = rst_n & (pc_upd | (branch & taken));
   assign IRWrite   = rst_n & ir_we;
   assign MemWrite  = rst_n & mem_we;
   assign RegWrite  = rst_n & reg_we;
   assign illegal   = illegal_q;
   assign state_dbg = STATE_W'(state_q);

endmodule
